// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master bit engine: command codes, phase
// state encoding, default timing constants and small command classifiers.
package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'b000,
        CMD_READ  = 3'b001,
        CMD_START = 3'b010,
        CMD_STOP  = 3'b011,
        CMD_DATA0 = 3'b100,
        CMD_DATA1 = 3'b101,
        CMD_ACK   = 3'b110,
        CMD_NACK  = 3'b111
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PH_A  = 3'd1,
        ST_PH_B  = 3'd2,
        ST_PH_C  = 3'd3,
        ST_PH_D  = 3'd4,
        ST_ABORT = 3'd5
    } state_e;

    localparam int DEF_QUARTER_CYCLES = 4;
    localparam int DEF_STRETCH_LIMIT  = 1024;
    localparam int DEF_CNT_W          = 16;

    // SDA enable applied when entering phase B (1 = pull low).
    function automatic logic phase_b_sda(cmd_e c);
        logic [2:0] code;
        code = c;
        case (c)
            CMD_START, CMD_READ: return 1'b0;
            CMD_STOP:            return 1'b1;
            default:             return ~code[0];
        endcase
    endfunction

    // Commands that release SDA as a driven '1' and must watch for another master.
    function automatic logic arb_applies(cmd_e c);
        return (c == CMD_DATA1) || (c == CMD_NACK);
    endfunction

    // Commands whose phase D samples SDA into rx_bit.
    function automatic logic samples_rx(cmd_e c);
        return (c == CMD_READ) || (c == CMD_DATA0) || (c == CMD_DATA1) ||
               (c == CMD_ACK)  || (c == CMD_NACK);
    endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// Quarter-bit phase counter with a separate SCL stretch counter.
// phase_end marks the last counting cycle of a phase; stretch_expired marks the
// cycle on which the stretch counter reaches STRETCH_LIMIT.
module i2c_phase_timer #(
    parameter int QUARTER_CYCLES = 4,
    parameter int STRETCH_LIMIT  = 1024,
    parameter int CNT_W          = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic run,
    input  logic scl_high,
    output logic phase_end,
    output logic stretch_expired
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(QUARTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] STR_LAST = CNT_W'(STRETCH_LIMIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] str_q, str_d;

    // Count quarter-cycle time while SCL is high, stretch time while it is held low.
    always_comb begin
        cnt_d = cnt_q;
        str_d = str_q;
        if (clear) begin
            cnt_d = '0;
            str_d = '0;
        end else if (run) begin
            if (scl_high) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                str_d = str_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt_q <= '0;
            str_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            str_q <= str_d;
        end
    end

    assign phase_end       = run & scl_high & (cnt_q == CNT_LAST);
    assign stretch_expired = run & ~scl_high & (str_q == STR_LAST);

endmodule

// File: rtl/i2c_master_bit_engine.sv
// Bit-level I2C master: runs one bus primitive per command through four
// quarter-bit phases, with clock stretching, arbitration-loss detection and a
// stretch timeout. Line enables are registered so they change only on edges.
module i2c_master_bit_engine
    import i2c_pkg::*;
#(
    parameter int QUARTER_CYCLES = DEF_QUARTER_CYCLES,
    parameter int STRETCH_LIMIT  = DEF_STRETCH_LIMIT,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] command,
    output logic       done,
    output logic       rx_bit,
    output logic       arb_lost,
    output logic       timeout,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_in,
    input  logic       sda_in
);

    state_e state_q, state_d;
    cmd_e   cmd_q, cmd_d;
    cmd_e   cmd_in;
    logic   scl_oe_q, scl_oe_d;
    logic   sda_oe_q, sda_oe_d;
    logic   done_q, done_d;
    logic   arb_q, arb_d;
    logic   to_q, to_d;
    logic   rx_q, rx_d;
    logic   idle_q, idle_d;
    logic   first_q;
    logic   abort_req;
    logic   arb_fail;
    logic   tmr_clear, tmr_run, tmr_scl_high;
    logic   phase_end, stretch_expired;

    assign cmd_in = cmd_e'(command);

    // Phase C only counts while SCL is really high; other phases ignore the line.
    assign tmr_run      = (state_q == ST_PH_A) || (state_q == ST_PH_B) ||
                          (state_q == ST_PH_C) || (state_q == ST_PH_D);
    assign tmr_scl_high = (state_q == ST_PH_C) ? scl_in : 1'b1;
    assign tmr_clear    = (state_d != state_q);

    // Another master pulled SDA low while we released it for a '1'.
    assign arb_fail = arb_applies(cmd_q) && !sda_oe_q && !sda_in &&
                      (((state_q == ST_PH_C) && scl_in) || (state_q == ST_PH_D));

    i2c_phase_timer #(
        .QUARTER_CYCLES (QUARTER_CYCLES),
        .STRETCH_LIMIT  (STRETCH_LIMIT),
        .CNT_W          (CNT_W)
    ) u_timer (
        .clock           (clock),
        .reset_n         (reset_n),
        .clear           (tmr_clear),
        .run             (tmr_run),
        .scl_high        (tmr_scl_high),
        .phase_end       (phase_end),
        .stretch_expired (stretch_expired)
    );

    // Next-state logic: phase sequencing plus the line action of the phase being entered.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        scl_oe_d  = scl_oe_q;
        sda_oe_d  = sda_oe_q;
        done_d    = 1'b0;
        arb_d     = arb_q;
        to_d      = to_q;
        rx_d      = rx_q;
        idle_d    = idle_q;
        abort_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    cmd_d = cmd_in;
                    arb_d = 1'b0;
                    to_d  = 1'b0;
                    case (cmd_in)
                        CMD_NOP: done_d = 1'b1;
                        CMD_START: begin
                            // From an idle bus SCL and SDA are already released.
                            if (idle_q) begin
                                state_d  = ST_PH_C;
                                scl_oe_d = 1'b0;
                            end else begin
                                state_d  = ST_PH_A;
                                scl_oe_d = 1'b1;
                            end
                        end
                        default: begin
                            state_d  = ST_PH_A;
                            scl_oe_d = 1'b1;
                        end
                    endcase
                end
            end
            ST_PH_A: begin
                if (phase_end) begin
                    state_d  = ST_PH_B;
                    sda_oe_d = phase_b_sda(cmd_q);
                end
            end
            ST_PH_B: begin
                if (phase_end) begin
                    state_d  = ST_PH_C;
                    scl_oe_d = 1'b0;
                end
            end
            ST_PH_C: begin
                if (stretch_expired) begin
                    abort_req = 1'b1;
                    to_d      = 1'b1;
                end else if (arb_fail) begin
                    abort_req = 1'b1;
                    arb_d     = 1'b1;
                end else if (phase_end) begin
                    state_d = ST_PH_D;
                    if (cmd_q == CMD_START) begin
                        sda_oe_d = 1'b1;
                    end else if (cmd_q == CMD_STOP) begin
                        sda_oe_d = 1'b0;
                    end
                end
            end
            ST_PH_D: begin
                if (first_q && samples_rx(cmd_q)) begin
                    rx_d = sda_in;
                end
                if (arb_fail) begin
                    abort_req = 1'b1;
                    arb_d     = 1'b1;
                end else if (phase_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (cmd_q == CMD_START) begin
                        idle_d = 1'b0;
                    end else if (cmd_q == CMD_STOP) begin
                        idle_d = 1'b1;
                    end
                end
            end
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Aborts release both lines and treat the bus as free again.
        if (abort_req) begin
            state_d  = ST_ABORT;
            scl_oe_d = 1'b0;
            sda_oe_d = 1'b0;
            idle_d   = 1'b1;
            done_d   = 1'b1;
        end
    end

    // State, line-enable and flag registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cmd_q    <= CMD_NOP;
            scl_oe_q <= 1'b0;
            sda_oe_q <= 1'b0;
            done_q   <= 1'b0;
            arb_q    <= 1'b0;
            to_q     <= 1'b0;
            rx_q     <= 1'b0;
            idle_q   <= 1'b1;
            first_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            scl_oe_q <= scl_oe_d;
            sda_oe_q <= sda_oe_d;
            done_q   <= done_d;
            arb_q    <= arb_d;
            to_q     <= to_d;
            rx_q     <= rx_d;
            idle_q   <= idle_d;
            first_q  <= (state_d != state_q);
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = done_q;
    assign rx_bit    = rx_q;
    assign arb_lost  = arb_q;
    assign timeout   = to_q;
    assign scl_oe    = scl_oe_q;
    assign sda_oe    = sda_oe_q;

endmodule

// File: doc/i2c_master_bit_engine.md
Name: i2c_master_bit_engine

Overview:
- Parametrised bit-level I2C master engine; next generation of the single-bit writer.
- Executes one bus primitive per command: START or repeated START, STOP, write 0/1, ACK/NACK, and the new READ_BIT.
- Drives open-drain enables and observes the real bus lines, which adds clock stretching, arbitration-loss detection, a stretch timeout and configurable bit timing.
- Sits between the byte-level controller FSM and the pad open-drain buffers.

Parameters:
- QUARTER_CYCLES, 4: clock cycles per quarter-bit phase (≥1).
- STRETCH_LIMIT, 1024: maximum cycles SCL may be held low by a slave in phase C before timeout (≥1).
- CNT_W, 16: width of the phase/stretch counters; must hold max(QUARTER_CYCLES, STRETCH_LIMIT).

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine can accept a command
- command  in  3  000 NOP, 001 READ_BIT, 010 START, 011 STOP, 100 DATA_0, 101 DATA_1, 110 ACK, 111 NACK
- done  out  1  one-cycle pulse when a command completes or aborts
- rx_bit  out  1  SDA value sampled by the last READ_BIT/DATA/ACK/NACK; held until the next sample
- arb_lost  out  1  qualifies done: the bit was aborted on arbitration loss
- timeout  out  1  qualifies done: the bit was aborted on stretch timeout
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- scl_in  in  1  synchronised SCL line level
- sda_in  in  1  synchronised SDA line level

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-low.
  - At reset: scl_oe=0, sda_oe=0, done=0, arb_lost=0, timeout=0, rx_bit=0, cmd_ready=1, state IDLE, bus_idle flag=1.
  - Reset mid-command releases both lines on the reset edge; no done pulse.
- Handshake:
  - A command is accepted on a cycle with cmd_valid & cmd_ready.
  - cmd_ready=1 only in IDLE and deasserts the cycle after acceptance.
  - done pulses for exactly 1 cycle on the cycle after the final phase cycle; cmd_ready returns to 1 in that same cycle.
  - NOP: done pulses the cycle after acceptance; no line change.
- States: IDLE, PH_A, PH_B, PH_C, PH_D, ABORT.
  - PH_A, PH_B and PH_D each last QUARTER_CYCLES cycles.
  - PH_C counts QUARTER_CYCLES only while scl_in=1. While scl_in=0, the stretch counter increments.
  - Stretch counter reaching STRETCH_LIMIT → ABORT with timeout=1.
- Per-command line actions (sda_oe value is the inverse of the bit driven):
  - DATA/ACK/NACK: A scl_oe=1, SDA unchanged; B set sda_oe; C scl_oe=0; D hold. rx_bit is sampled at the first PH_D cycle.
  - READ_BIT: as DATA_1 (sda_oe=0), with no arbitration check.
  - START: A scl_oe=1; B sda_oe=0; C scl_oe=0; D sda_oe=1.
    - If bus_idle=1, PH_A and PH_B are skipped.
    - Ends with SCL released, SDA low; clears bus_idle.
  - STOP: A scl_oe=1; B sda_oe=1; C scl_oe=0; D sda_oe=0. Sets bus_idle.
- Arbitration:
  - Applies to DATA_1 and NACK during PH_C (counting cycles) and PH_D.
  - sda_in=0 while sda_oe=0 → ABORT with arb_lost=1.
- ABORT (1 cycle): scl_oe=0, sda_oe=0, bus_idle=1, done=1 with the flag set, then IDLE.
- Flags clear on the next command acceptance.
- Command input is ignored while cmd_ready=0; only the latched command is used.

Decomposition:
- Package i2c_pkg holds:
  - the 3-bit command codes;
  - the phase state encoding (IDLE, PH_A..PH_D, ABORT);
  - shared default timing constants.
- Sub-module i2c_phase_timer:
  - inputs: clear, run, scl_high;
  - outputs: phase_end, stretch_expired;
  - parametrised by QUARTER_CYCLES, STRETCH_LIMIT, CNT_W.

Test Plan (QUARTER_CYCLES=2, STRETCH_LIMIT=8, bus pulled up, scl_in/sda_in = NOT oe unless overridden):
- After reset, START → lines: sda_oe rises at cycle 3 after accept; done at cycle 5; SCL never pulled; cmd_ready=0 during cycles 1-4.
- START then DATA_0, DATA_1, STOP → each data bit done 9 cycles after accept; SDA changes only while scl_oe=1; STOP ends with scl_oe=sda_oe=0.
- READ_BIT with slave forcing sda_in=0 → rx_bit=0 at done; arb_lost=0.
- DATA_1 with sda_in forced 0 during PH_C → done with arb_lost=1; both oe=0 that cycle; next START skips PH_A/PH_B.
- DATA_0 with scl_in held low 3 cycles in PH_C → done delayed by exactly 3 cycles; scl_in held low 8 cycles → done with timeout=1.
- reset_n low during PH_B of DATA_0 → both oe=0 on the next edge; no done; cmd_ready=1 after release.
